bs_serializer: RTL and testbench

//   Parallel-to-bit-serial transmitter: accepts a WIDTH-bit two's-complement word over a

---
 rtl/bs_serializer_if.sv | 24 ++
 rtl/bs_serializer.sv | 99 +++++++++
 tb/tb_bs_serializer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/bs_serializer_if.sv
// Handshake and serial-bus bundle for bs_serializer.
// master: word source and downstream stall driver. slave: the serializer itself.
interface bs_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             s_stall;
  logic             s_out;
  logic             s_valid;
  logic             s_first;
  logic             s_last;

  modport master (
    output in_data, in_valid, s_stall,
    input  in_ready, s_out, s_valid, s_first, s_last
  );

  modport slave (
    input  in_data, in_valid, s_stall,
    output in_ready, s_out, s_valid, s_first, s_last
  );
endinterface

// File: rtl/bs_serializer.sv
// bs_serializer: parallel-to-bit-serial transmitter, LSB first, one bit per clk.
// Words enter over a valid/ready handshake; s_first/s_last frame each word so
// downstream bit-serial stages can clear their per-word state.
// Optional feature macro: SIGN_EXT_EN -- when defined each word is emitted as
// 2*WIDTH bits, the upper WIDTH bits repeating the word MSB (sign extension).
module bs_serializer #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  bs_serializer_if.slave bus
);

`ifdef SIGN_EXT_EN
  localparam int NBITS = 2 * WIDTH;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CNT_W = $clog2(NBITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBITS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic signed [WIDTH-1:0]   r_sreg;
  logic signed [WIDTH-1:0]   w_sreg_nxt;
  logic [CNT_W-1:0]          r_cnt;
  logic [CNT_W-1:0]          w_cnt_nxt;
  logic                      w_shift;
  logic                      w_last;
  logic                      w_accept;

  assign w_shift  = (r_state == SHIFT);
  assign w_last   = w_shift && (r_cnt == LAST_CNT);

  // A new word may enter when idle, or on the final bit of the current word
  // provided that bit is actually leaving this cycle (no stall) -- this gives
  // bubble-free back-to-back words.
  assign bus.in_ready = rst_n & (~w_shift | (w_last & ~bus.s_stall));
  assign w_accept     = bus.in_valid & bus.in_ready;

  // Outputs come straight from registered state and are forced low outside a word.
  assign bus.s_valid = w_shift;
  assign bus.s_out   = w_shift & r_sreg[0];
  assign bus.s_first = w_shift & (r_cnt == '0);
  assign bus.s_last  = w_last;

  // Next-state: load, arithmetic shift (MSB copy supplies sign extension), hold on stall.
  always_comb begin
    w_state_nxt = r_state;
    w_sreg_nxt  = r_sreg;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = SHIFT;
          w_sreg_nxt  = $signed(bus.in_data);
          w_cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        if (!bus.s_stall) begin
          if (!w_last) begin
            w_sreg_nxt = r_sreg >>> 1;
            w_cnt_nxt  = r_cnt + 1'b1;
          end else if (w_accept) begin
            w_sreg_nxt = $signed(bus.in_data);
            w_cnt_nxt  = '0;
          end else begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, shift register and bit counter; reset aborts any word in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sreg  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sreg  <= w_sreg_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_bs_serializer.sv
// Testbench for bs_serializer (WIDTH=8). Reference model: a queue holding the
// bits still to be emitted for the word in flight, each tagged first/last.
module tb_bs_serializer;

  localparam int W = 8;
`ifdef SIGN_EXT_EN
  localparam int NB = 2 * W;
`else
  localparam int NB = W;
`endif

  typedef struct packed {
    logic b;
    logic f;
    logic l;
  } ebit_t;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  ebit_t q[$];

  bs_serializer_if #(.WIDTH(W)) bus ();

  bs_serializer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    ebit_t e;
    for (int k = 0; k < NB; k++) begin
      e.b = (k < W) ? w[k] : w[W-1];
      e.f = (k == 0);
      e.l = (k == NB - 1);
      q.push_back(e);
    end
  endtask

  // Called at a negedge: apply inputs, check outputs, advance model across the next posedge.
  task automatic cycle(input logic rn, input logic v, input logic [W-1:0] d,
                       input logic st, output bit acc);
    ebit_t e;
    logic  ev;
    logic  erdy;
    rst_n        = rn;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.s_stall  = st;
    #1;
    ev   = (q.size() > 0);
    e    = ev ? q[0] : '0;
    erdy = rn && (q.size() == 0 || (q.size() == 1 && !st));
    chk("s_valid",  bus.s_valid,  ev);
    chk("s_out",    bus.s_out,    e.b);
    chk("s_first",  bus.s_first,  e.f);
    chk("s_last",   bus.s_last,   e.l);
    chk("in_ready", bus.in_ready, erdy);
    acc = rn && v && erdy;
    if (!rn) begin
      q.delete();
    end else if (acc) begin
      if (q.size() > 0) void'(q.pop_front());
      push_word(d);
    end else if (q.size() > 0 && !st) begin
      void'(q.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, '0, 1'b0, a);
  endtask

  // Hold in_valid/in_data until the word is accepted (bounded).
  task automatic send(input logic [W-1:0] w);
    bit a;
    int n;
    a = 0;
    n = 0;
    while (!a && n < 100) begin
      cycle(1'b1, 1'b1, w, 1'b0, a);
      n++;
    end
    if (!a) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: observed=not_accepted expected=accepted word=%h", w);
    end
  endtask

  initial begin
    bit a;
    int n;
    logic [W-1:0] w;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.s_stall  = 1'b0;
    @(negedge clk);

    // Reset held two clocks, then idle.
    cycle(1'b0, 1'b0, '0, 1'b0, a);
    cycle(1'b0, 1'b1, 8'hAA, 1'b0, a);
    idle(2);

    // Single word B5, then drain to IDLE.
    send(8'hB5);
    idle(NB + 2);

    // Word with negative MSB (sign-extension visible when enabled).
    send(8'h85);
    idle(NB + 2);

    // Back-to-back: 01 then FF with valid held.
    send(8'h01);
    send(8'hFF);
    idle(NB + 2);

    // Stall three clocks on bit 2 of 3C.
    send(8'h3C);
    idle(2);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b1, a);
    idle(NB + 2);

    // Reset on bit 4 of A5, then 0F sends cleanly.
    send(8'hA5);
    idle(4);
    cycle(1'b0, 1'b0, '0, 1'b0, a);
    idle(1);
    send(8'h0F);
    idle(NB + 2);

    // Stall while presenting a new word on the last bit: must not be accepted.
    send(8'h5A);
    idle(NB - 1);
    cycle(1'b1, 1'b1, 8'hC3, 1'b1, a);
    send(8'hC3);
    idle(NB + 2);

    // Randomized traffic: random words, gaps, stalls and occasional reset.
    for (int k = 0; k < 40; k++) begin
      w = W'($urandom);
      a = 0;
      n = 0;
      while (!a && n < 200) begin
        if ($urandom_range(0, 59) == 0)
          cycle(1'b0, 1'b1, w, 1'b0, a);
        else
          cycle(1'b1, 1'b1, w, ($urandom_range(0, 3) == 0), a);
        n++;
      end
      if (!a) begin
        checks++;
        errors++;
        $error("FAIL rand_timeout: observed=not_accepted expected=accepted word=%h", w);
      end
      n = $urandom_range(0, NB + 2);
      for (int j = 0; j < n; j++)
        cycle(1'b1, 1'b0, W'($urandom), ($urandom_range(0, 3) == 0), a);
    end
    idle(2 * NB + 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
